uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver; replaces the fixed 8N1 receiver in the serial front end.
//  Adds configurable data width, parity and stop bits, an rx synchroniser, false-start
//  rejection, parity/framing error flags and break recovery. Feeds the byte sink/FIFO.
// PARAMETERS
//  CLKS_PER_BIT  4  clk cycles per bit; legal >= 4 (5208 = 9600 baud @ 50 MHz)
//  DATA_BITS     8  payload bits per frame; legal 5..9; LSB received first
//  PARITY        0  0 = none, 1 = odd, 2 = even
//  STOP_BITS     1  1 or 2; every stop bit is checked
// PORTS
//  clk         in   1          system clock, rising edge
//  arst_n      in   1          reset arst_n, asynchronous, active-high
//  rx          in   1          serial line, idle high, asynchronous to clk
//  data_out    out  DATA_BITS  last received payload; held until next valid
//  valid       out  1          1-cycle pulse: data_out/err flags updated
//  parity_err  out  1          parity mismatch on frame flagged by valid
//  frame_err   out  1          a stop bit sampled low on frame flagged by valid
//  busy        out  1          high in any state other than IDLE
// BEHAVIOUR
//  - Reset (arst_n=1): all state to IDLE, counters 0, sync FFs 1; data_out=0, valid=0,
//    parity_err=0, frame_err=0, busy=0. Reset mid-frame discards the frame, no valid.
//  - rx passes a 2-FF synchroniser (rx_s); all decisions use rx_s (+2 cycles latency).
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (IDLE | BREAK).
//  - IDLE: rx_s==0 -> START, cnt=0.
//  - START: at cnt==CLKS_PER_BIT/2-1 sample; rx_s==1 -> IDLE (glitch, no valid, no flag);
//    else -> DATA, cnt=0, bit_idx=0.
//  - DATA: sample at cnt==CLKS_PER_BIT-1 (mid-bit), shift into bit DATA_BITS-1 of shift
//    reg right-shifting; after bit_idx==DATA_BITS-1 -> PARITY if PARITY!=0 else STOP.
//  - PARITY: one bit, sampled mid-bit; err = (^data ^ p) != (PARITY==1).
//  - STOP: STOP_BITS samples mid-bit; any low sample sets frame error.
//    After last stop sample: next cycle data_out<=shift reg, flags<=computed, valid=1 one
//    cycle. frame error and rx_s==0 -> BREAK; otherwise -> IDLE (new start edge
//    recognised from the cycle after valid).
//  - BREAK: wait rx_s==1, then IDLE; no valid produced while in BREAK.
//  - Flags are registered with valid and held until next valid; never sticky across frames.
//  - Counter width $clog2(CLKS_PER_BIT); bit_idx width $clog2(DATA_BITS+1); no wrap
//    beyond terminal counts (reset to 0 at each sample).
//  - rx edges mid-bit are ignored; only mid-bit samples matter.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each sample (start, data, parity, stop) is the
//    2-of-3 majority of rx_s at cnt==mid-1, mid, mid+1; decision/state update one cycle
//    later than the plain case, valid latency +1 cycle; requires CLKS_PER_BIT >= 6.
//  Not defined: single sample of rx_s at mid-bit exactly as described above.
// TESTING  (defaults unless stated, clk 20 ns, bit time CLKS_PER_BIT*clk)
//  1 send 0xA5 8N1 -> one valid pulse, data_out=8'hA5, parity_err=0, frame_err=0,
//    busy low after valid.
//  2 PARITY=2: send 0x3C with parity 0 -> 8'h3C, parity_err=0; with parity 1 ->
//    parity_err=1, data_out=8'h3C.
//  3 send 0x55 with stop bit 0 then rx held low 3 bit times -> valid, frame_err=1; busy
//    stays high until rx returns high; no second valid.
//  4 rx low for 1 clk then high -> no valid, busy returns 0 within CLKS_PER_BIT/2+3 clk.
//  5 DATA_BITS=7, STOP_BITS=2: back-to-back 0x7F,0x00 -> two valids, correct data;
//    second stop low -> frame_err=1 on that frame only.
//  6 assert arst_n mid-DATA of 0xFF, release, send 0x12 -> only one valid, data_out=0x12.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity, 1-2 stop bits, break recovery.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit (needs CLKS_PER_BIT >= 6).
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  // Decision lands one cycle after mid so the third vote is available.
  localparam logic [CW-1:0] START_LAST = CW'(CLKS_PER_BIT / 2);
`else
  localparam logic [CW-1:0] START_LAST = CW'(CLKS_PER_BIT / 2 - 1);
`endif
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 state_reg, state_next;
  logic                   rx_meta_reg, rx_s_reg;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [IW-1:0]          idx_reg, idx_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   par_bad_reg, par_bad_next;
  logic                   stop_bad_reg, stop_bad_next;
  logic [DATA_BITS-1:0]   data_reg, data_next;
  logic                   valid_reg, valid_next;
  logic                   perr_reg, perr_next;
  logic                   ferr_reg, ferr_next;
  logic                   sample;
  logic                   frame_bad;

  always_ff @(posedge clk or posedge arst_n) begin
    if (arst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_reg;

  always_ff @(posedge clk or posedge arst_n) begin
    if (arst_n) hist_reg <= 2'b11;
    else        hist_reg <= {hist_reg[0], rx_s_reg};
  end

  assign sample = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rx_s_reg) |
                  (hist_reg[0] & rx_s_reg);
`else
  assign sample = rx_s_reg;
`endif

  assign frame_bad = stop_bad_reg | ~sample;

  always_ff @(posedge clk or posedge arst_n) begin
    if (arst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      shift_reg    <= '0;
      par_bad_reg  <= 1'b0;
      stop_bad_reg <= 1'b0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      shift_reg    <= shift_next;
      par_bad_reg  <= par_bad_next;
      stop_bad_reg <= stop_bad_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      perr_reg     <= perr_next;
      ferr_reg     <= ferr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    shift_next    = shift_reg;
    par_bad_next  = par_bad_reg;
    stop_bad_next = stop_bad_reg;
    data_next     = data_reg;
    valid_next    = 1'b0;
    perr_next     = perr_reg;
    ferr_next     = ferr_reg;
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (!rx_s_reg && !valid_reg) state_next = S_START;
      end
      S_START: begin
        if (cnt_reg == START_LAST) begin
          cnt_next = '0;
          if (sample) begin
            state_next = S_IDLE;
          end else begin
            state_next   = S_DATA;
            idx_next     = '0;
            par_bad_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {sample, shift_reg[DATA_BITS-1:1]};
          if (idx_reg == DATA_LAST) begin
            idx_next      = '0;
            stop_bad_next = 1'b0;
            state_next    = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_PARITY: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next      = '0;
          par_bad_next  = ((^shift_reg) ^ sample) != ODD;
          stop_bad_next = 1'b0;
          state_next    = S_STOP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (idx_reg == STOP_LAST) begin
            idx_next   = '0;
            data_next  = shift_reg;
            valid_next = 1'b1;
            perr_next  = (PARITY != 0) ? par_bad_reg : 1'b0;
            ferr_next  = frame_bad;
            // A low line at the failed stop is treated as a break condition.
            state_next = (frame_bad && !rx_s_reg) ? S_BREAK : S_IDLE;
          end else begin
            idx_next      = idx_reg + IW'(1);
            stop_bad_next = frame_bad;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s_reg) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign data_out   = data_reg;
  assign valid      = valid_reg;
  assign parity_err = perr_reg;
  assign frame_err  = ferr_reg;
  assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 8E1, 7N2) share clock and reset.
module tb_uart_rx_cfg;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic arst_n = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;

  logic [7:0] data0, data1;
  logic [6:0] data2;
  logic valid0, valid1, valid2;
  logic perr0, perr1, perr2;
  logic ferr0, ferr1, ferr2;
  logic busy0, busy1, busy2;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB)) d0 (
    .clk(clk), .arst_n(arst_n), .rx(rx0), .data_out(data0), .valid(valid0),
    .parity_err(perr0), .frame_err(ferr0), .busy(busy0));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .PARITY(2)) d1 (
    .clk(clk), .arst_n(arst_n), .rx(rx1), .data_out(data1), .valid(valid1),
    .parity_err(perr1), .frame_err(ferr1), .busy(busy1));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2)) d2 (
    .clk(clk), .arst_n(arst_n), .rx(rx2), .data_out(data2), .valid(valid2),
    .parity_err(perr2), .frame_err(ferr2), .busy(busy2));

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       busy;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int which, input logic [8:0] d, input logic pe,
                      input logic fe, input logic bz);
    exp_t e;
    e = '{data: d, perr: pe, ferr: fe, busy: bz};
    case (which)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic cmp(input int which, input exp_t e, input logic [8:0] d,
                     input logic pe, input logic fe, input logic bz);
    $display("d%0d frame data=%03h parity_err=%0b frame_err=%0b busy=%0b", which, d, pe, fe, bz);
    chk($sformatf("d%0d_data", which), 32'(d), 32'(e.data));
    chk($sformatf("d%0d_parity_err", which), 32'(pe), 32'(e.perr));
    chk($sformatf("d%0d_frame_err", which), 32'(fe), 32'(e.ferr));
    chk($sformatf("d%0d_busy_at_valid", which), 32'(bz), 32'(e.busy));
  endtask

  task automatic drive(input int which, input logic b);
    case (which)
      0:       rx0 = b;
      1:       rx1 = b;
      default: rx2 = b;
    endcase
  endtask

  task automatic send_bit(input int which, input logic b);
    drive(which, b);
    repeat (CPB) @(negedge clk);
  endtask

  // par < 0 means no parity bit; stop bits go out stops[0] first.
  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input int par, input logic [1:0] stops, input int nstops);
    send_bit(which, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(which, data[i]);
    if (par >= 0) send_bit(which, par[0]);
    for (int i = 0; i < nstops; i++) send_bit(which, stops[i]);
  endtask

  task automatic idle(input int which, input int nbits);
    drive(which, 1'b1);
    repeat (nbits * CPB) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_d0_data", 32'(data0), 0);  chk("rst_d0_valid", 32'(valid0), 0);
    chk("rst_d0_perr", 32'(perr0), 0);  chk("rst_d0_ferr", 32'(ferr0), 0);
    chk("rst_d0_busy", 32'(busy0), 0);
    chk("rst_d1_data", 32'(data1), 0);  chk("rst_d1_valid", 32'(valid1), 0);
    chk("rst_d1_busy", 32'(busy1), 0);
    chk("rst_d2_data", 32'(data2), 0);  chk("rst_d2_valid", 32'(valid2), 0);
    chk("rst_d2_busy", 32'(busy2), 0);
    arst_n = 1'b0;
    repeat (4) @(negedge clk);

    fork
      begin : monitor
        while (!done) begin
          @(negedge clk);
          if (valid0) begin
            if (q0.size() == 0) begin
              checks++; errors++;
              $display("FAIL d0_unexpected_valid actual=valid data=%02h required=no_valid", data0);
            end else cmp(0, q0.pop_front(), {1'b0, data0}, perr0, ferr0, busy0);
          end
          if (valid1) begin
            if (q1.size() == 0) begin
              checks++; errors++;
              $display("FAIL d1_unexpected_valid actual=valid data=%02h required=no_valid", data1);
            end else cmp(1, q1.pop_front(), {1'b0, data1}, perr1, ferr1, busy1);
          end
          if (valid2) begin
            if (q2.size() == 0) begin
              checks++; errors++;
              $display("FAIL d2_unexpected_valid actual=valid data=%02h required=no_valid", data2);
            end else cmp(2, q2.pop_front(), {2'b0, data2}, perr2, ferr2, busy2);
          end
        end
      end
      begin : stimulus
        // 0xA5 8N1
        push(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9'h0A5, 8, -1, 2'b01, 1);
        idle(0, 2);

        // one-clock glitch must be rejected
        rx0 = 1'b0;
        @(negedge clk);
        rx0 = 1'b1;
        repeat (CPB / 2 + 3) @(negedge clk);
        chk("glitch_busy_released", 32'(busy0), 0);
        idle(0, 2);

        // 0x55 with low stop, then line held low: break
        push(0, 9'h055, 1'b0, 1'b1, 1'b1);
        send_frame(0, 9'h055, 8, -1, 2'b00, 1);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b0);
        chk("break_busy_held", 32'(busy0), 1);
        rx0 = 1'b1;
        repeat (4) @(negedge clk);
        chk("break_busy_released", 32'(busy0), 0);
        idle(0, 2);

        // even parity: good then bad parity bit
        push(1, 9'h03C, 1'b0, 1'b0, 1'b0);
        send_frame(1, 9'h03C, 8, 0, 2'b01, 1);
        idle(1, 2);
        push(1, 9'h03C, 1'b1, 1'b0, 1'b0);
        send_frame(1, 9'h03C, 8, 1, 2'b01, 1);
        idle(1, 2);

        // 7N2 back-to-back, then second stop low, then clean frame
        push(2, 9'h07F, 1'b0, 1'b0, 1'b0);
        send_frame(2, 9'h07F, 7, -1, 2'b11, 2);
        push(2, 9'h000, 1'b0, 1'b0, 1'b0);
        send_frame(2, 9'h000, 7, -1, 2'b11, 2);
        idle(2, 2);
        push(2, 9'h015, 1'b0, 1'b1, 1'b1);
        send_frame(2, 9'h015, 7, -1, 2'b01, 2);
        idle(2, 2);
        push(2, 9'h033, 1'b0, 1'b0, 1'b0);
        send_frame(2, 9'h033, 7, -1, 2'b11, 2);
        idle(2, 2);

        // reset in the middle of 0xFF, then 0x12
        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_data", 32'(data0), 0);
        chk("midrst_ferr", 32'(ferr0), 0);
        arst_n = 1'b0;
        repeat (4) @(negedge clk);
        push(0, 9'h012, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9'h012, 8, -1, 2'b01, 1);
        idle(0, 3);

        for (int k = 0; k < 200 && (q0.size() + q1.size() + q2.size()) > 0; k++)
          @(negedge clk);
        chk("d0_all_frames_seen", 32'(q0.size()), 0);
        chk("d1_all_frames_seen", 32'(q1.size()), 0);
        chk("d2_all_frames_seen", 32'(q2.size()), 0);
        done = 1'b1;
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
